// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : Two-port arbiter in front of the single-port data memory.
//            Port A (pipeline MEM stage) has priority; port B (loader/DMA)
//            is guaranteed a grant after MAX_WAIT consecutive lost cycles.
//            Grants are same-cycle, read data returns one cycle later.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
  parameter int ADDR_W   = 9,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  // port A: pipeline MEM stage
  input  logic              i_a_req,
  input  logic              i_a_we,
  input  logic [ADDR_W-1:0] i_a_addr,
  input  logic [DATA_W-1:0] i_a_wdata,
  output logic              o_a_gnt,
  output logic              o_a_stall,
  output logic              o_a_rvalid,
  output logic [DATA_W-1:0] o_a_rdata,
  // port B: secondary master
  input  logic              i_b_req,
  input  logic              i_b_we,
  input  logic [ADDR_W-1:0] i_b_addr,
  input  logic [DATA_W-1:0] i_b_wdata,
  output logic              o_b_gnt,
  output logic              o_b_rvalid,
  output logic [DATA_W-1:0] o_b_rdata,
  // memory side
  output logic [ADDR_W-1:0] o_mem_address,
  output logic [DATA_W-1:0] o_mem_write_data,
  output logic              o_mem_write,
  output logic              o_mem_read,
  input  logic [DATA_W-1:0] i_mem_read_data
);

  // Four bits cover the whole legal MAX_WAIT range of 1..15.
  localparam int                 c_CNT_W    = 4;
  localparam logic [c_CNT_W-1:0] c_WAIT_MAX = c_CNT_W'(MAX_WAIT);

  logic [c_CNT_W-1:0] r_wait_cnt;
  logic               r_last_b;
  logic               r_a_rvalid;
  logic               r_b_rvalid;
  logic [DATA_W-1:0]  r_a_rdata;
  logic [DATA_W-1:0]  r_b_rdata;

  logic               w_b_wins;
  logic               w_a_gnt;
  logic               w_b_gnt;
  logic               w_unused_dbg;

  // Arbitration: B wins when A is idle or when B has been starved long enough.
  always_comb begin
    w_b_wins = i_b_req & (~i_a_req | (r_wait_cnt >= c_WAIT_MAX));
    w_b_gnt  = rst_n & w_b_wins;
    w_a_gnt  = rst_n & i_a_req & ~w_b_wins;
  end

  // Memory mux: granted port drives the memory; A's fields when nobody is granted.
  always_comb begin
    o_mem_address    = i_a_addr;
    o_mem_write_data = i_a_wdata;
    o_mem_write      = 1'b0;
    o_mem_read       = 1'b0;
    if (w_b_gnt) begin
      o_mem_address    = i_b_addr;
      o_mem_write_data = i_b_wdata;
      o_mem_write      = i_b_we;
      o_mem_read       = ~i_b_we;
    end else if (w_a_gnt) begin
      o_mem_write      = i_a_we;
      o_mem_read       = ~i_a_we;
    end
  end

  // Starvation counter, read-return registers and the B-grant debug flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wait_cnt <= '0;
      r_last_b   <= 1'b0;
      r_a_rvalid <= 1'b0;
      r_b_rvalid <= 1'b0;
      r_a_rdata  <= '0;
      r_b_rdata  <= '0;
    end else begin
      r_last_b   <= w_b_gnt;
      r_a_rvalid <= w_a_gnt & ~i_a_we;
      r_b_rvalid <= w_b_gnt & ~i_b_we;
      if (w_a_gnt && !i_a_we) begin
        r_a_rdata <= i_mem_read_data;
      end
      if (w_b_gnt && !i_b_we) begin
        r_b_rdata <= i_mem_read_data;
      end
      if (w_b_gnt || !i_b_req) begin
        r_wait_cnt <= '0;
      end else if (r_wait_cnt < c_WAIT_MAX) begin
        r_wait_cnt <= r_wait_cnt + 1'b1;
      end
    end
  end

  // last_b is an observation-only tap; it has no consumer inside the arbiter.
  assign w_unused_dbg = r_last_b;

  assign o_a_gnt    = w_a_gnt;
  assign o_b_gnt    = w_b_gnt;
  assign o_a_stall  = i_a_req & ~w_a_gnt;
  assign o_a_rvalid = r_a_rvalid;
  assign o_b_rvalid = r_b_rvalid;
  assign o_a_rdata  = r_a_rdata;
  assign o_b_rdata  = r_b_rdata;

endmodule
`default_nettype wire
